// File: rtl/sdram_arb.sv
// sdram_arb: three-port arbiter in front of the sram controller command port.
// Fixed priority 0 > 1 > 2 with a starvation override for port 2 and a ready timeout.
module sdram_arb #(
  parameter int unsigned AW      = 25,
  parameter int unsigned DW      = 16,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned STARVE  = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [2:0]      req,
  input  logic [3*AW-1:0] addr_in,
  input  logic [3*DW-1:0] din_in,
  input  logic [2:0]      we_in,
  input  logic [5:0]      wtbt_in,
  output logic [2:0]      ack,
  output logic            err,
  output logic [DW-1:0]   dout,
  output logic            busy,
  output logic [1:0]      grant_id,
  output logic [AW-1:0]   ram_addr,
  output logic [DW-1:0]   ram_din,
  output logic [1:0]      ram_wtbt,
  output logic            ram_rd,
  output logic            ram_we,
  input  logic [DW-1:0]   ram_dout,
  input  logic            ram_ready
);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;

  localparam logic [7:0] STARVE_LIM = 8'(STARVE);
  localparam logic [7:0] WAIT_LAST  = 8'(TIMEOUT - 1);

  state_t          r_state, w_state_nxt;
  logic [7:0]      r_wait_cnt, r_starve_cnt;
  logic            r_we;
  logic [2:0]      r_ack;
  logic            r_err;
  logic [DW-1:0]   r_dout;
  logic [1:0]      r_grant;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_din;
  logic [1:0]      r_wtbt;
  logic            r_rd_stb, r_we_stb;

  logic [2:0]      w_elig;
  logic            w_grant;
  logic [1:0]      w_win;
  logic [AW-1:0]   w_addr;
  logic [DW-1:0]   w_din;
  logic [1:0]      w_wtbt;
  logic            w_we;
  logic            w_done, w_tmo;
  logic [2:0]      w_ack_vec;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_elig      = req & ~r_ack;
    w_grant     = 1'b0;
    w_win       = 2'd2;
    w_done      = 1'b0;
    w_tmo       = 1'b0;
    w_state_nxt = r_state;
    w_ack_vec   = '0;

    // A port acked this cycle is masked so a held req is not serviced twice.
    if (w_elig[2] && (r_starve_cnt >= STARVE_LIM)) w_win = 2'd2;
    else if (w_elig[0])                            w_win = 2'd0;
    else if (w_elig[1])                            w_win = 2'd1;

    case (w_win)
      2'd0: begin
        w_addr = addr_in[0*AW +: AW]; w_din = din_in[0*DW +: DW];
        w_wtbt = wtbt_in[1:0];        w_we  = we_in[0];
      end
      2'd1: begin
        w_addr = addr_in[1*AW +: AW]; w_din = din_in[1*DW +: DW];
        w_wtbt = wtbt_in[3:2];        w_we  = we_in[1];
      end
      default: begin
        w_addr = addr_in[2*AW +: AW]; w_din = din_in[2*DW +: DW];
        w_wtbt = wtbt_in[5:4];        w_we  = we_in[2];
      end
    endcase

    case (r_grant)
      2'd0:    w_ack_vec = 3'b001;
      2'd1:    w_ack_vec = 3'b010;
      2'd2:    w_ack_vec = 3'b100;
      default: w_ack_vec = 3'b000;
    endcase

    case (r_state)
      ST_IDLE: begin
        if (|w_elig) begin
          w_grant     = 1'b1;
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (ram_ready) begin
          w_done      = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (r_wait_cnt == WAIT_LAST) begin
          w_tmo       = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wait_cnt   <= '0;
      r_starve_cnt <= '0;
      r_we         <= 1'b0;
      r_ack        <= '0;
      r_err        <= 1'b0;
      r_dout       <= '0;
      r_grant      <= 2'd3;
      r_addr       <= '0;
      r_din        <= '0;
      r_wtbt       <= '0;
      r_rd_stb     <= 1'b0;
      r_we_stb     <= 1'b0;
    end else begin
      r_ack    <= '0;
      r_err    <= 1'b0;
      r_rd_stb <= 1'b0;
      r_we_stb <= 1'b0;

      if (w_grant) begin
        r_addr   <= w_addr;
        r_din    <= w_din;
        r_wtbt   <= w_wtbt;
        r_we     <= w_we;
        r_grant  <= w_win;
        r_rd_stb <= ~w_we;
        r_we_stb <= w_we;
      end

      if (r_state == ST_ISSUE)     r_wait_cnt <= '0;
      else if (r_state == ST_WAIT) r_wait_cnt <= r_wait_cnt + 8'd1;

      if (w_done || w_tmo) begin
        r_ack   <= w_ack_vec;
        r_err   <= w_tmo;
        r_grant <= 2'd3;
      end

      if (w_done && !r_we) r_dout <= ram_dout;
      else if (w_tmo)      r_dout <= '0;

      if (!req[2])               r_starve_cnt <= '0;
      else if (w_grant) begin
        if (w_win == 2'd2)             r_starve_cnt <= '0;
        else if (r_starve_cnt != '1)   r_starve_cnt <= r_starve_cnt + 8'd1;
      end
    end
  end

  assign ack      = r_ack;
  assign err      = r_err;
  assign dout     = r_dout;
  assign busy     = (r_state != ST_IDLE);
  assign grant_id = r_grant;
  assign ram_addr = r_addr;
  assign ram_din  = r_din;
  assign ram_wtbt = r_wtbt;
  assign ram_rd   = r_rd_stb;
  assign ram_we   = r_we_stb;

endmodule

// File: tb/tb_sdram_arb.sv
// Directed bench for sdram_arb: table of single accesses, then hand-written
// arbitration-order, starvation, timeout and mid-access reset sequences.
`timescale 1ns/1ps
module tb_sdram_arb;
  localparam int AW = 25;
  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [2:0]      req;
  logic [3*AW-1:0] addr_in;
  logic [3*DW-1:0] din_in;
  logic [2:0]      we_in;
  logic [5:0]      wtbt_in;
  logic [2:0]      ack;
  logic            err;
  logic [DW-1:0]   dout;
  logic            busy;
  logic [1:0]      grant_id;
  logic [AW-1:0]   ram_addr;
  logic [DW-1:0]   ram_din;
  logic [1:0]      ram_wtbt;
  logic            ram_rd, ram_we;
  logic [DW-1:0]   ram_dout;
  logic            ram_ready;

  sdram_arb #(.AW(AW), .DW(DW), .TIMEOUT(8), .STARVE(4)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .addr_in(addr_in), .din_in(din_in),
    .we_in(we_in), .wtbt_in(wtbt_in), .ack(ack), .err(err), .dout(dout),
    .busy(busy), .grant_id(grant_id), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_wtbt(ram_wtbt), .ram_rd(ram_rd), .ram_we(ram_we), .ram_dout(ram_dout),
    .ram_ready(ram_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Controller model: ready resp_lat cycles after a strobe.
  logic            resp_en = 1'b0;
  int              resp_lat = 1;
  logic [DW-1:0]   resp_data = '0;
  initial begin
    ram_ready = 1'b0;
    ram_dout  = '0;
    forever begin
      @(negedge clk);
      if (resp_en && (ram_rd || ram_we)) begin
        repeat (resp_lat) @(negedge clk);
        ram_ready = 1'b1;
        ram_dout  = resp_data;
        @(negedge clk);
        ram_ready = 1'b0;
      end
    end
  end

  int            n_strobe = 0;
  int            n_ack    = 0;
  bit            overlap  = 1'b0;
  int            cap_cyc  = 0;
  logic [AW-1:0] cap_addr;
  logic [DW-1:0] cap_din;
  logic [1:0]    cap_wtbt, cap_gid;
  logic          cap_we;
  initial begin
    forever begin
      @(negedge clk);
      if (ack != 3'b000) n_ack++;
      if (ram_rd || ram_we) begin
        n_strobe++;
        if (ram_rd && ram_we) overlap = 1'b1;
        cap_cyc  = cyc;
        cap_addr = ram_addr;
        cap_din  = ram_din;
        cap_wtbt = ram_wtbt;
        cap_gid  = grant_id;
        cap_we   = ram_we;
      end
    end
  end

  task automatic wait_ack(output logic [2:0] a, output int at);
    a  = 3'b000;
    at = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (ack != 3'b000) begin
        a  = ack;
        at = cyc;
        return;
      end
    end
    n_checks++;
    n_fail++;
    $display("FAIL ack_wait: actual=no ack in 60 cycles expected=ack");
  endtask

  typedef struct {
    int          port;
    logic        we;
    logic [24:0] addr;
    logic [15:0] din;
    logic [1:0]  wtbt;
    int          lat;
    logic [15:0] rdata;
    logic [15:0] exp_dout;
  } vec_t;

  vec_t       vecs[7];
  logic [2:0] a;
  int         at, rq, s0, n0, p;
  logic [2:0] exp_seq[10];

  initial begin
    vecs[0] = '{1, 1'b0, 25'h0001234, 16'h0000, 2'b11, 4, 16'hA5C3, 16'hA5C3};
    vecs[1] = '{2, 1'b1, 25'h1FFFFFF, 16'hBEEF, 2'b01, 2, 16'h7777, 16'hA5C3};
    vecs[2] = '{0, 1'b0, 25'h0000000, 16'h0000, 2'b11, 1, 16'h1357, 16'h1357};
    vecs[3] = '{0, 1'b1, 25'h0000010, 16'h1234, 2'b10, 1, 16'h9999, 16'h1357};
    vecs[4] = '{2, 1'b0, 25'h0ABCDEF, 16'h0000, 2'b11, 3, 16'hFFFF, 16'hFFFF};
    vecs[5] = '{1, 1'b1, 25'h1000000, 16'h0000, 2'b11, 7, 16'h2222, 16'hFFFF};
    vecs[6] = '{1, 1'b0, 25'h0155555, 16'h0000, 2'b11, 8, 16'h4321, 16'h4321};
    exp_seq = '{3'b001, 3'b010, 3'b001, 3'b010, 3'b100,
                3'b001, 3'b010, 3'b001, 3'b010, 3'b100};

    reset_n = 1'b0; req = '0; addr_in = '0; din_in = '0; we_in = '0; wtbt_in = '0;
    repeat (2) @(negedge clk);
    check("rst_ack", ack, 0);
    check("rst_err", err, 0);
    check("rst_dout", dout, 0);
    check("rst_busy", busy, 0);
    check("rst_grant", grant_id, 3);
    check("rst_addr", ram_addr, 0);
    check("rst_din", ram_din, 0);
    check("rst_wtbt", ram_wtbt, 0);
    check("rst_strobes", {ram_rd, ram_we}, 0);
    reset_n = 1'b1;
    @(negedge clk);
    resp_en = 1'b1;

    for (int v = 0; v < 7; v++) begin
      p         = vecs[v].port;
      resp_lat  = vecs[v].lat;
      resp_data = vecs[v].rdata;
      addr_in[p*AW +: AW]  = vecs[v].addr;
      din_in[p*DW +: DW]   = vecs[v].din;
      we_in[p]             = vecs[v].we;
      wtbt_in[2*p +: 2]    = vecs[v].wtbt;
      s0 = n_strobe;
      rq = cyc;
      req[p] = 1'b1;
      wait_ack(a, at);
      req[p] = 1'b0;
      check($sformatf("v%0d_ack", v), a, 32'(3'b001 << p));
      check($sformatf("v%0d_err", v), err, 0);
      check($sformatf("v%0d_dout", v), dout, vecs[v].exp_dout);
      check($sformatf("v%0d_nstrobe", v), n_strobe, s0 + 1);
      check($sformatf("v%0d_strobe_cyc", v), cap_cyc, rq + 1);
      check($sformatf("v%0d_ack_cyc", v), at, cap_cyc + vecs[v].lat + 1);
      check($sformatf("v%0d_we", v), cap_we, vecs[v].we);
      check($sformatf("v%0d_addr", v), cap_addr, vecs[v].addr);
      check($sformatf("v%0d_din", v), cap_din, vecs[v].din);
      check($sformatf("v%0d_wtbt", v), cap_wtbt, vecs[v].wtbt);
      check($sformatf("v%0d_gid", v), cap_gid, p);
      @(negedge clk);
      check($sformatf("v%0d_ack_pulse", v), ack, 0);
      check($sformatf("v%0d_gid_idle", v), grant_id, 3);
    end

    // All three reads at once: strict priority order.
    addr_in = {25'h0000300, 25'h0000200, 25'h0000100};
    we_in = 3'b000;
    resp_lat = 1; resp_data = 16'h5A5A;
    s0 = n_strobe;
    req = 3'b111;
    for (int k = 0; k < 3; k++) begin
      wait_ack(a, at);
      req = req & ~a;
      check($sformatf("order%0d", k), a, 32'(3'b001 << k));
    end
    check("order_nstrobe", n_strobe, s0 + 3);
    check("order_overlap", overlap, 0);
    n0 = n_ack;
    repeat (8) @(negedge clk);
    #1;
    check("order_no_extra_ack", n_ack, n0);

    // Ports 0/1 keep requesting; port 2 forced after four lost arbitrations.
    req = 3'b111;
    for (int k = 0; k < 10; k++) begin
      wait_ack(a, at);
      if (k == 9) req = 3'b000;
      check($sformatf("starve%0d", k), a, exp_seq[k]);
    end
    repeat (3) @(negedge clk);

    // Timeout: no ready, then a stray ready in IDLE is ignored.
    resp_en = 1'b0;
    addr_in[1*AW +: AW] = 25'h0000777;
    we_in[1] = 1'b0;
    req[1] = 1'b1;
    wait_ack(a, at);
    req[1] = 1'b0;
    check("tmo_ack", a, 3'b010);
    check("tmo_err", err, 1);
    check("tmo_dout", dout, 0);
    check("tmo_cyc", at, cap_cyc + 9);
    @(negedge clk);
    check("tmo_err_pulse", err, 0);
    n0 = n_ack;
    ram_ready = 1'b1;
    @(negedge clk);
    ram_ready = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    check("stray_ready_ack", n_ack, n0);
    check("stray_ready_busy", busy, 0);

    // Reset during WAIT aborts; held request re-arbitrated afterwards.
    addr_in[0 +: AW] = 25'h0000ABC;
    we_in[0] = 1'b0;
    req[0] = 1'b1;
    repeat (2) @(negedge clk);
    check("mid_busy", busy, 1);
    #1 reset_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_grant", grant_id, 3);
    check("arst_addr", ram_addr, 0);
    check("arst_strobes", {ram_rd, ram_we}, 0);
    check("arst_ack", ack, 0);
    n0 = n_ack;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    resp_en = 1'b1; resp_lat = 2; resp_data = 16'hC0DE;
    wait_ack(a, at);
    req[0] = 1'b0;
    check("rearb_ack", a, 3'b001);
    check("rearb_err", err, 0);
    check("rearb_dout", dout, 16'hC0DE);
    check("rearb_addr", cap_addr, 25'h0000ABC);
    #1;
    check("rearb_ack_count", n_ack, n0 + 1);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
